stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-to-1 stream multiplexer with round-robin arbitration, valid/ready handshakes and a registered output stage. It is the sequential successor to the plain 2-to-1 data mux. Instead of using an external select, it chooses among `NUM_INPUTS` producer channels by itself and forwards one beat per cycle to a single consumer. It reports which channel each output beat came from.

## Interface
- `BIT_WIDTH`, default 8: data width per channel; must be >= 1.
- `NUM_INPUTS`, default 4: number of input channels; must be >= 1.
- `SEL_W`, default `(NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1`: derived width of the select index. Do not override.

Ports:
- `clk_i` input 1: clock. One clock domain. All state updates on the rising edge.
- `rst_i` input 1: reset. Synchronous and active-high.
- `valid_i` input `[NUM_INPUTS]`: per-channel beat valid.
- `data_i` input `[NUM_INPUTS][BIT_WIDTH]`: per-channel data.
- `ready_o` output `[NUM_INPUTS]`: per-channel accept. Combinational and one-hot or zero.
- `valid_o` output 1: output register holds a beat.
- `data_o` output `BIT_WIDTH`: output data.
- `sel_o` output `SEL_W`: index of the channel that supplied the `data_o` beat.
- `ready_i` input 1: consumer accept.
- `last_i` input `[NUM_INPUTS]`, only with `STREAM_MUX_LOCK_EN`: end-of-packet flag per channel.
- `last_o` output 1, only with `STREAM_MUX_LOCK_EN`: end-of-packet flag of the beat in `data_o`.

## Operation
- `load = !valid_o || ready_i`. When this is true, the output register may take a new beat this cycle.
- **Arbitration:** the search starts at `(last_grant + 1) mod NUM_INPUTS` and scans indices in increasing order with wrap-around. The first index with `valid_i` set wins and becomes the grant `g`.
- **Accepting a beat:** `ready_o[g] = load && any(valid_i)`. All other `ready_o` bits are 0. A transfer on channel g happens when `valid_i[g] && ready_o[g]`.
- **On a transfer:** `data_o <= data_i[g]`, `sel_o <= g`, `valid_o <= 1`, `last_grant <= g`.
- **Idle load:** when `load` is true and no `valid_i` is set, `valid_o <= 0`. `data_o` and `sel_o` hold their values and `last_grant` is unchanged.
- **Backpressure:** when `valid_o && !ready_i`, all outputs hold and `ready_o` is 0.
- **Simultaneous drain and refill:** when `ready_i` is 1 and a new beat is granted in the same cycle, there is no bubble.
- **Single channel (`NUM_INPUTS == 1`):** behaves as a one-stage register slice. `sel_o` is always 0.
- **Fairness:** a channel that holds `valid_i` high is granted within `NUM_INPUTS` transfers.
- **Reset values:**
  - `valid_o = 0`, `data_o = 0`, `sel_o = 0`, `last_o = 0`.
  - `last_grant = NUM_INPUTS-1`, so channel 0 has first priority.
  - lock is cleared.
  - `ready_o` is 0 while `rst_i` is high.
- **Reset mid-operation:** any held beat is discarded, with no partial transfer.

## Timing
- Latency is one cycle: a beat accepted at edge k appears on `data_o` and `valid_o` after edge k.
- Throughput is one beat per cycle while `ready_i` stays high.
- `ready_o` depends combinationally on `valid_i`, `ready_i` and `valid_o`. Upstream logic must not make `valid_i` depend on `ready_o`.
- `valid_i` must stay high, with `data_i` stable, until that channel's transfer occurs. This block does not check the rule.
- `valid_o`, `data_o`, `sel_o` and `last_o` are register outputs only.

## Configuration
- Macro: `STREAM_MUX_LOCK_EN`.
- **Defined (packet lock):**
  - Adds the `last_i` and `last_o` ports.
  - A transfer from channel g with `last_i[g] = 0` sets the lock to g.
  - While locked, the grant is forced to g, even when `valid_i[g]` is 0. No other channel gets `ready_o`.
  - A transfer from g with `last_i[g] = 1` clears the lock.
  - `last_o` is registered with the data.
- **Undefined:** the `last` ports are absent, there is no lock state, and every beat is arbitrated independently.

## Test plan
Test configuration: `BIT_WIDTH = 8`, `NUM_INPUTS = 4`.
- **Reset:** hold `rst_i` high for 2 cycles with `valid_i = 4'b1111`. Required: `valid_o = 0`, `data_o = 0x00`, `sel_o = 0`, `ready_o = 4'b0000`.
- **Round-robin:** all channels valid with data 0x10/0x21/0x32/0x43 and `ready_i = 1`. Required: `data_o` = 0x10, 0x21, 0x32, 0x43, 0x10 on consecutive cycles, with `sel_o` = 0, 1, 2, 3, 0.
- **Backpressure:** `ready_i = 0` for 5 cycles while `data_o = 0x21`. Required: `data_o` and `sel_o` stable and `ready_o = 0` throughout. When `ready_i` rises, 0x32 is loaded at that edge with no bubble.
- **Sparse traffic:** only channel 2 valid and `ready_i = 1`. Required: `ready_o = 4'b0100` every cycle, one beat per cycle, `sel_o = 2`. When channel 2 drops valid, `valid_o` falls the next cycle.
- **Lock (`STREAM_MUX_LOCK_EN`):** channel 1 sends 3 beats with `last` = 0, 0, 1 while channels 0 and 3 are also valid. Required: the three channel-1 beats appear contiguously, then channel 3 is granted, then channel 0. If channel 1 goes idle for 2 cycles mid-packet, `valid_o` bubbles and no other channel is granted.
- **Reset mid-packet:** assert `rst_i` while the lock is held and `valid_o = 1`. Required: after the edge, `valid_o = 0` and the lock is cleared, and the first grant after reset is channel 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 round-robin stream multiplexer with a registered output slice.
// Define STREAM_MUX_LOCK_EN to add packet lock (last_i/last_o) so a packet is never interleaved.
module stream_mux_rr #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_INPUTS-1:0]                valid_i,
  input  logic [NUM_INPUTS-1:0][BIT_WIDTH-1:0] data_i,
  output logic [NUM_INPUTS-1:0]                ready_o,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [NUM_INPUTS-1:0]                last_i,
  output logic                                 last_o,
`endif
  output logic                                 valid_o,
  output logic [BIT_WIDTH-1:0]                 data_o,
  output logic [SEL_W-1:0]                     sel_o,
  input  logic                                 ready_i
);

  logic             load;
  logic             any_valid;
  logic             xfer;
  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] rr_grant;
  logic [SEL_W-1:0] grant;

  // Scans last+1, last+2, ... with wrap; walking backwards lets the nearest requester win.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_INPUTS-1:0] req,
                                               input logic [SEL_W-1:0]      last);
    int idx;
    rr_pick = last;
    for (int k = NUM_INPUTS; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_INPUTS;
      if (req[idx]) rr_pick = SEL_W'(idx);
    end
  endfunction

  assign any_valid = |valid_i;
  assign load      = !valid_o || ready_i;
  assign rr_grant  = rr_pick(valid_i, last_grant);

`ifdef STREAM_MUX_LOCK_EN
  logic             locked;
  logic [SEL_W-1:0] lock_idx;

  // A locked packet owns the output even while its producer pauses.
  assign grant = locked ? lock_idx : rr_grant;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked   <= 1'b0;
      lock_idx <= '0;
      last_o   <= 1'b0;
    end else if (xfer) begin
      locked   <= !last_i[grant];
      lock_idx <= grant;
      last_o   <= last_i[grant];
    end
  end
`else
  assign grant = rr_grant;
`endif

  always_comb begin
    // NOTE: default assignment first so every path drives ready_o and no latch is inferred.
    ready_o = '0;
    if (!rst_i && load && any_valid) ready_o[grant] = 1'b1;
  end

  assign xfer = valid_i[grant] && ready_o[grant];

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the data/select registers are reset too, so an idle output is deterministic.
      valid_o    <= 1'b0;
      data_o     <= '0;
      sel_o      <= '0;
      last_grant <= SEL_W'(NUM_INPUTS - 1);
    end else if (load) begin
      valid_o <= xfer;
      if (xfer) begin
        data_o     <= data_i[grant];
        sel_o      <= grant;
        last_grant <= grant;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: per-cycle vector table plus a beat scoreboard.
// Lock sequences run only when STREAM_MUX_LOCK_EN is defined.
module tb_stream_mux_rr;

  localparam int BW = 8;
  localparam int NI = 4;
  localparam int SW = 2;

  typedef struct {
    logic          rst;
    logic [NI-1:0] valid;
    logic          ready;
    logic [31:0]   data;
    logic [NI-1:0] exp_ready;
    logic          exp_valid;
    logic [NI-1:0] last;
  } vec_t;

  typedef struct {
    logic [BW-1:0] data;
    logic [SW-1:0] sel;
    logic          last;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NI-1:0]          valid = '0;
  logic [NI-1:0][BW-1:0]  data = '0;
  logic                   ready = 1'b0;
  logic [NI-1:0]          ready_o;
  logic                   valid_o;
  logic [BW-1:0]          data_o;
  logic [SW-1:0]          sel_o;
`ifdef STREAM_MUX_LOCK_EN
  logic [NI-1:0]          last = '1;
  logic                   last_o;
`endif

  int    checks   = 0;
  int    failures = 0;
  beat_t sb[$];
  vec_t  vecs[$];

  always #5 clk = ~clk;

  stream_mux_rr #(.BIT_WIDTH(BW), .NUM_INPUTS(NI)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid),
    .data_i  (data),
    .ready_o (ready_o),
`ifdef STREAM_MUX_LOCK_EN
    .last_i  (last),
    .last_o  (last_o),
`endif
    .valid_o (valid_o),
    .data_o  (data_o),
    .sel_o   (sel_o),
    .ready_i (ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [NI-1:0] v, input logic rd,
                              input logic [31:0] d, input logic [NI-1:0] er, input logic ev,
                              input logic [NI-1:0] l = '1);
    vec_t x;
    x.rst = r; x.valid = v; x.ready = rd; x.data = d;
    x.exp_ready = er; x.exp_valid = ev; x.last = l;
    return x;
  endfunction

  task automatic apply(input vec_t v);
    logic [NI-1:0] won;
    beat_t         e;
    @(negedge clk);
    rst   = v.rst;
    valid = v.valid;
    data  = v.data;
    ready = v.ready;
`ifdef STREAM_MUX_LOCK_EN
    last  = v.last;
`endif
    #1;
    check("ready_o", ready_o, v.exp_ready);
    // Consumer takes the held beat at the coming edge.
    if (!v.rst && valid_o && ready) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pop_data", data_o, e.data);
        check("pop_sel", sel_o, e.sel);
`ifdef STREAM_MUX_LOCK_EN
        check("pop_last", last_o, e.last);
`endif
      end
    end
    won = v.exp_ready & v.valid;
    if (!v.rst) begin
      for (int i = 0; i < NI; i++) begin
        if (won[i]) begin
          e.data = v.data[i*BW +: BW];
          e.sel  = SW'(i);
          e.last = v.last[i];
          sb.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    if (v.rst) begin
      sb.delete();
      check("rst_data_o", data_o, 0);
      check("rst_sel_o", sel_o, 0);
`ifdef STREAM_MUX_LOCK_EN
      check("rst_last_o", last_o, 0);
`endif
    end
    check("valid_o", valid_o, v.exp_valid);
    if (v.exp_valid && sb.size() != 0) begin
      check("held_data", data_o, sb[0].data);
      check("held_sel", sel_o, sb[0].sel);
    end
  endtask

  initial begin
    logic [31:0] d0;
    logic [31:0] sp;
    d0 = 32'h43322110;
    sp = 32'h00A00000;

    // Reset with every channel requesting.
    vecs.push_back(mk(1, 4'b1111, 0, d0, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b1111, 0, d0, 4'b0000, 0));
    // Round-robin 0,1,2,3,0 then 1.
    vecs.push_back(mk(0, 4'b1111, 1, d0, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b1111, 1, d0, 4'b0010, 1));
    vecs.push_back(mk(0, 4'b1111, 1, d0, 4'b0100, 1));
    vecs.push_back(mk(0, 4'b1111, 1, d0, 4'b1000, 1));
    vecs.push_back(mk(0, 4'b1111, 1, d0, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b1111, 1, d0, 4'b0010, 1));
    // Backpressure for 5 cycles while 0x21 is held, then refill without a bubble.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 4'b1111, 0, d0, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b1111, 1, d0, 4'b0100, 1));
    // Sparse traffic on channel 2 only, then it drops valid.
    vecs.push_back(mk(0, 4'b0100, 1, sp,                4'b0100, 1));
    vecs.push_back(mk(0, 4'b0100, 1, sp + 32'h00010000, 4'b0100, 1));
    vecs.push_back(mk(0, 4'b0100, 1, sp + 32'h00020000, 4'b0100, 1));
    vecs.push_back(mk(0, 4'b0000, 1, d0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 1, d0, 4'b0000, 0));
    // Mixed requesters with wrap-around and a stall.
    vecs.push_back(mk(0, 4'b1010, 1, d0, 4'b1000, 1));
    vecs.push_back(mk(0, 4'b1010, 1, d0, 4'b0010, 1));
    vecs.push_back(mk(0, 4'b1001, 1, d0, 4'b1000, 1));
    vecs.push_back(mk(0, 4'b1001, 0, d0, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b1001, 1, d0, 4'b0001, 1));
    // Reset while a beat is held; first grant afterwards is channel 0.
    vecs.push_back(mk(0, 4'b1111, 1, d0, 4'b0010, 1));
    vecs.push_back(mk(1, 4'b1111, 0, d0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1111, 1, d0, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0000, 1, d0, 4'b0000, 0));

    foreach (vecs[i]) apply(vecs[i]);

`ifdef STREAM_MUX_LOCK_EN
    // Channel 1 packet (last 0,0,1) with a 2-cycle pause while channels 0 and 3 wait.
    apply(mk(0, 4'b1011, 1, d0, 4'b0010, 1, 4'b0000));
    apply(mk(0, 4'b1011, 1, d0, 4'b0010, 1, 4'b0000));
    apply(mk(0, 4'b1001, 1, d0, 4'b0010, 0, 4'b0000));
    apply(mk(0, 4'b1001, 1, d0, 4'b0010, 0, 4'b0000));
    apply(mk(0, 4'b1011, 1, d0, 4'b0010, 1, 4'b0010));
    apply(mk(0, 4'b1011, 1, d0, 4'b1000, 1, 4'b1111));
    apply(mk(0, 4'b1011, 1, d0, 4'b0001, 1, 4'b1111));
    // Reset mid-packet clears the lock.
    apply(mk(0, 4'b0010, 1, d0, 4'b0010, 1, 4'b0000));
    apply(mk(1, 4'b1011, 0, d0, 4'b0000, 0, 4'b0000));
    apply(mk(0, 4'b1011, 1, d0, 4'b0001, 1, 4'b1111));
    apply(mk(0, 4'b0000, 1, d0, 4'b0000, 0, 4'b1111));
`endif

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
